serial_subtractor: RTL

- Multi-cycle bit-serial subtractor; the inverse-direction companion to the team's combinational ripple adder (A, B, Cin -> S, Cout).
- Computes D = A - B - Bin and a borrow-out Bout, one bit per clock, LSB first, through a single borrow flip-flop.
- Uses a start/busy/done handshake so a controller or bench can issue operations and collect results.

---
 rtl/serial_subtractor_if.sv | 35 +++
 rtl/serial_subtractor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The borrow-overflow flag V exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             V;
`endif

  // Controller side: issues operations, collects results.
  modport master (
    output start, A, B, Bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  V,
`endif
    input  D, Bout, busy, done
  );

  // Subtractor side.
  modport slave (
    input  start, A, B, Bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output V,
`endif
    output D, Bout, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// through a single borrow flop. start/busy/done handshake; results are
// registered and only change on completion.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds the signed-overflow flag V.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [1:0]       bit_res;
  logic             last;

  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             busy_c;
  logic             done_c;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             v_q;
`endif

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bi);
    logic d;
    logic bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, d};
  endfunction

  assign bit_res = sub_bit(a_sr[0], b_sr[0], br);
  assign r_nxt   = {bit_res[0], r_sr[WIDTH-1:1]};
  assign last    = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start only honoured in IDLE; RUN lasts exactly WIDTH edges.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      RUN:     busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath: load on start, shift during RUN, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      v_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr <= bus.A;
            b_sr <= bus.B;
            br   <= bus.Bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_nxt;
          br   <= bit_res[1];
          cnt  <= cnt + CW'(1);
          if (last) begin
            d_q    <= r_nxt;
            bout_q <= bit_res[1];
`ifdef SERIAL_SUB_OVERFLOW_EN
            // br here is the borrow into the MSB stage.
            v_q    <= br ^ bit_res[1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.busy = busy_c;
  assign bus.done = done_c;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.V    = v_q;
`endif

endmodule
